// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// with a sticky TRAP on unsupported opcodes and a retired-instruction counter.
module mc_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     cur, nxt;
  logic [6:0] opcode_q;
  logic       legal;
  logic       retire;
  logic       is_load, is_store, is_short;

  // Legality is judged on the live opcode, which is what DECODE latches.
  always_comb begin
    case (opcode)
      OP_OP, OP_IMM, OP_LOAD, OP_FENCE, OP_JALR,
      OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: legal = 1'b1;
      default:                                       legal = 1'b0;
    endcase
  end

  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);
  assign is_short = (opcode_q == OP_BRANCH) || (opcode_q == OP_FENCE);

  always_comb begin
    nxt       = cur;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    case (cur)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          nxt      = DECODE;
        end
      end
      DECODE: nxt = legal ? EXECUTE : TRAP;
      EXECUTE: begin
        if (is_load || is_store) begin
          nxt = MEMORY;
        end else if (is_short) begin
          retire = 1'b1;
          nxt    = FETCH;
        end else begin
          nxt = WRITEBACK;
        end
      end
      MEMORY: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ready) begin
          if (is_store) begin
            retire = 1'b1;
            nxt    = FETCH;
          end else begin
            nxt = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = FETCH;
      end
      TRAP:    nxt = TRAP;
      default: nxt = FETCH;
    endcase
    // Reset masks every strobe combinationally, even before the edge lands.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

  assign pc_write = retire;
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= FETCH;
      opcode_q     <= '0;
      illegal      <= 1'b0;
      retire_count <= '0;
    end else begin
      cur <= nxt;
      if (cur == DECODE) begin
        opcode_q <= opcode;
        if (!legal) illegal <= 1'b1;
      end
      if (retire) retire_count <= retire_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-instruction expected traces are
// generated from the latency/strobe rules and compared cycle by cycle.
module tb_mc_sequencer;

  localparam int W = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   opcode;
  logic         mem_ready;
  logic [2:0]   state;
  logic         mem_req, mem_we, ir_write, pc_write, reg_write, illegal;
  logic [W-1:0] retire_count;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_cnt;
  logic         exp_ill;

  // Expected trace: {state, mem_req, mem_we, ir_write, pc_write, reg_write}
  logic [7:0] ex[$];
  int         rd[$];   // 0/1 = mem_ready value, 2 = don't care (randomised)
  bit         dp[$];   // drive the instruction opcode in this cycle

  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0001111,
                                 7'b1100111, 7'b0100011, 7'b1100011, 7'b0110111,
                                 7'b0010111, 7'b1101111};

  mc_sequencer #(.CNT_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .state        (state),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .illegal      (illegal),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {state, mem_req, mem_we, ir_write, pc_write, reg_write};
  endfunction

  function automatic void add(logic [7:0] e, int r, bit d);
    ex.push_back(e);
    rd.push_back(r);
    dp.push_back(d);
  endfunction

  // One instruction as the rules describe it: fw fetch waits, mw memory waits.
  function automatic void build(logic [6:0] op, int fw, int mw);
    ex.delete(); rd.delete(); dp.delete();
    for (int i = 0; i < fw; i++) add({3'd0, 5'b10000}, 0, 1'b0);
    add({3'd0, 5'b10100}, 1, 1'b0);
    add({3'd1, 5'b00000}, 2, 1'b1);
    if (op == OP_LOAD || op == OP_STORE) begin
      add({3'd2, 5'b00000}, 2, 1'b0);
      for (int i = 0; i < mw; i++) add({3'd3, 1'b1, op == OP_STORE, 3'b000}, 0, 1'b0);
      if (op == OP_LOAD) begin
        add({3'd3, 5'b10000}, 1, 1'b0);
        add({3'd4, 5'b00011}, 2, 1'b0);
      end else begin
        add({3'd3, 5'b11010}, 1, 1'b0);
      end
    end else if (op == OP_BR || op == OP_FENCE) begin
      add({3'd2, 5'b00010}, 2, 1'b0);
    end else begin
      add({3'd2, 5'b00000}, 2, 1'b0);
      add({3'd4, 5'b00011}, 2, 1'b0);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = OP_R;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (obs() !== 8'b0) begin n_err++; $display("FAIL reset_strobes got %b want %b", obs(), 8'b0); end
      n_cmp++; if (retire_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", retire_count); end
      n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp_cnt = '0;
    exp_ill = 1'b0;
  endtask

  task automatic test_instr(input logic [6:0] op, input int fw, input int mw, input string tag);
    build(op, fw, mw);
    foreach (ex[i]) begin
      rst = 1'b0;
      mem_ready = (rd[i] == 2) ? 1'($urandom_range(0, 1)) : (rd[i] == 1);
      opcode = dp[i] ? op : 7'($urandom_range(0, 127));
      @(negedge clk);
      n_cmp++; if (obs() !== ex[i]) begin n_err++; $display("FAIL %s op=%b cyc%0d state/strobes got %b want %b", tag, op, i, obs(), ex[i]); end
      n_cmp++; if (retire_count !== exp_cnt) begin n_err++; $display("FAIL %s cyc%0d count got %0d want %0d", tag, i, retire_count, exp_cnt); end
      n_cmp++; if (illegal !== exp_ill) begin n_err++; $display("FAIL %s cyc%0d illegal got %b want %b", tag, i, illegal, exp_ill); end
      if (ex[i][1]) exp_cnt = exp_cnt + W'(1);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      test_instr(legal_ops[$urandom_range(0, 9)], int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), "random");
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 16; k++) test_instr(OP_BR, int'($urandom_range(0, 2)), 0, "wrap");
    @(negedge clk);
    n_cmp++; if (retire_count !== '0) begin n_err++; $display("FAIL wrap_final count got %0d want 0", retire_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_trap();
    do_reset();
    test_instr(OP_R, 0, 0, "pre_trap");
    mem_ready = 1'b1;
    opcode = 7'($urandom_range(0, 127));
    @(negedge clk);
    n_cmp++; if (obs() !== {3'd0, 5'b10100}) begin n_err++; $display("FAIL trap_fetch got %b want %b", obs(), {3'd0, 5'b10100}); end
    @(posedge clk); #1;
    opcode = 7'b1111111;
    mem_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    n_cmp++; if (obs() !== {3'd1, 5'b00000}) begin n_err++; $display("FAIL trap_decode got %b want %b", obs(), {3'd1, 5'b00000}); end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      opcode = 7'($urandom_range(0, 127));
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_cmp++; if (obs() !== {3'd5, 5'b00000}) begin n_err++; $display("FAIL trap_hold cyc%0d got %b want %b", i, obs(), {3'd5, 5'b00000}); end
      n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL trap_illegal cyc%0d got %b want 1", i, illegal); end
      n_cmp++; if (retire_count !== exp_cnt) begin n_err++; $display("FAIL trap_count cyc%0d got %0d want %0d", i, retire_count, exp_cnt); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs() !== {3'd5, 5'b00000}) begin n_err++; $display("FAIL trap_rst_cycle got %b want %b", obs(), {3'd5, 5'b00000}); end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs() !== {3'd0, 5'b10000}) begin n_err++; $display("FAIL trap_after_rst got %b want %b", obs(), {3'd0, 5'b10000}); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL trap_after_rst_illegal got %b want 0", illegal); end
    n_cmp++; if (retire_count !== '0) begin n_err++; $display("FAIL trap_after_rst_count got %0d want 0", retire_count); end
    @(posedge clk); #1;
    exp_cnt = '0;
    exp_ill = 1'b0;
  endtask

  task automatic test_reset_mid_memory();
    logic [7:0] e [5] = '{{3'd0, 5'b10100}, {3'd1, 5'b00000}, {3'd2, 5'b00000},
                          {3'd3, 5'b10000}, {3'd3, 5'b10000}};
    bit         r [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    test_instr(OP_R, 0, 0, "pre_mid");
    for (int i = 0; i < 5; i++) begin
      mem_ready = r[i];
      opcode = (i == 1) ? OP_LOAD : 7'($urandom_range(0, 127));
      @(negedge clk);
      n_cmp++; if (obs() !== e[i]) begin n_err++; $display("FAIL mid_load cyc%0d got %b want %b", i, obs(), e[i]); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs() !== {3'd3, 5'b00000}) begin n_err++; $display("FAIL mid_rst_cycle got %b want %b", obs(), {3'd3, 5'b00000}); end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs() !== {3'd0, 5'b10000}) begin n_err++; $display("FAIL mid_after_rst got %b want %b", obs(), {3'd0, 5'b10000}); end
    n_cmp++; if (retire_count !== '0) begin n_err++; $display("FAIL mid_after_rst_count got %0d want 0", retire_count); end
    @(posedge clk); #1;
    exp_cnt = '0;
    exp_ill = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    opcode = '0;
    exp_cnt = '0;
    exp_ill = 1'b0;
    test_reset();
    test_instr(OP_R, 0, 0, "rtype");
    test_instr(OP_LOAD, 0, 3, "load_wait");
    test_instr(OP_STORE, 1, 2, "store");
    test_instr(OP_FENCE, 2, 0, "fence");
    test_random();
    test_wrap();
    test_trap();
    test_reset_mid_memory();
    test_instr(OP_STORE, 0, 0, "post_mid");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
